// File: rtl/text_buffer_writer.sv
// Character-RAM writer for the LCD text path: consumes an ASCII byte stream,
// tracks the cursor and issues glyph/blank writes, including screen and line clears.
module text_buffer_writer #(
   parameter int          COLS   = 100,
   parameter int          ROWS   = 30,
   parameter int          COL_W  = 7,
   parameter int          ROW_W  = 5,
   parameter int          ADDR_W = 12,
   parameter logic [7:0]  BLANK  = 8'h20
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              char_valid,
   input  logic [7:0]        char_data,
   output logic              char_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [COL_W-1:0]  cur_col,
   output logic [ROW_W-1:0]  cur_row,
   output logic              busy
);

   typedef enum logic [1:0] {
      INIT_CLR = 2'd0,
      IDLE     = 2'd1,
      LINE_CLR = 2'd2,
      FULL_CLR = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] A_ZERO    = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_COLS    = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
   localparam logic [COL_W-1:0]  C_ZERO    = {COL_W{1'b0}};
   localparam logic [COL_W-1:0]  C_ONE     = COL_W'(1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  R_ZERO    = {ROW_W{1'b0}};
   localparam logic [ROW_W-1:0]  R_ONE     = ROW_W'(1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [7:0]        CH_BS     = 8'h08;
   localparam logic [7:0]        CH_LF     = 8'h0A;
   localparam logic [7:0]        CH_FF     = 8'h0C;
   localparam logic [7:0]        CH_CR     = 8'h0D;

   state_t              state_r, next_state_s;
   logic [ADDR_W-1:0]   k_r, k_s;
   logic [ADDR_W-1:0]   row_base_r, row_base_s;
   logic [COL_W-1:0]    col_r, col_s;
   logic [ROW_W-1:0]    row_r, row_s;
   logic                ready_r, ready_s;
   logic                busy_r, busy_s;
   logic                wr_en_r, wr_en_s;
   logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
   logic [7:0]          wr_data_r, wr_data_s;

   logic                accept_s;
   logic                printable_s;
   logic [COL_W-1:0]    col_dec_s;
   logic [ROW_W-1:0]    adv_row_s;
   logic [ADDR_W-1:0]   adv_base_s;

   assign accept_s    = (state_r == IDLE) && char_valid && ready_r;
   assign printable_s = (char_data >= 8'h20) && (char_data <= 8'h7E);
   assign col_dec_s   = col_r - C_ONE;
   // Row advance wraps to the top instead of scrolling; row_base follows without a multiply.
   assign adv_row_s   = (row_r == ROW_LAST) ? R_ZERO : (row_r + R_ONE);
   assign adv_base_s  = (row_r == ROW_LAST) ? A_ZERO : (row_base_r + A_COLS);

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= INIT_CLR;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         INIT_CLR, FULL_CLR: begin
            if (k_r == CLR_LAST) next_state_s = IDLE;
            else                 next_state_s = state_r;
         end
         LINE_CLR: begin
            if (k_r == LINE_LAST) next_state_s = IDLE;
            else                  next_state_s = LINE_CLR;
         end
         IDLE: begin
            if (accept_s) begin
               if (printable_s)           next_state_s = (col_r == COL_LAST) ? LINE_CLR : IDLE;
               else if (char_data == CH_LF) next_state_s = LINE_CLR;
               else if (char_data == CH_FF) next_state_s = FULL_CLR;
               else                       next_state_s = IDLE;
            end else begin
               next_state_s = IDLE;
            end
         end
         default: next_state_s = INIT_CLR;
      endcase
   end

   // Output and datapath next values; ready only once a clear's last write has been shown.
   always_comb begin
      k_s        = k_r;
      col_s      = col_r;
      row_s      = row_r;
      row_base_s = row_base_r;
      wr_en_s    = 1'b0;
      wr_addr_s  = wr_addr_r;
      wr_data_s  = wr_data_r;
      case (state_r)
         INIT_CLR, FULL_CLR: begin
            wr_en_s   = 1'b1;
            wr_addr_s = k_r;
            wr_data_s = BLANK;
            if (k_r == CLR_LAST) begin
               k_s        = A_ZERO;
               col_s      = C_ZERO;
               row_s      = R_ZERO;
               row_base_s = A_ZERO;
            end else begin
               k_s = k_r + A_ONE;
            end
         end
         LINE_CLR: begin
            wr_en_s   = 1'b1;
            wr_addr_s = row_base_r + k_r;
            wr_data_s = BLANK;
            if (k_r == LINE_LAST) k_s = A_ZERO;
            else                  k_s = k_r + A_ONE;
         end
         IDLE: begin
            if (accept_s && printable_s) begin
               wr_en_s   = 1'b1;
               wr_addr_s = row_base_r + ADDR_W'(col_r);
               wr_data_s = char_data;
               if (col_r == COL_LAST) begin
                  col_s      = C_ZERO;
                  row_s      = adv_row_s;
                  row_base_s = adv_base_s;
                  k_s        = A_ZERO;
               end else begin
                  col_s = col_r + C_ONE;
               end
            end else if (accept_s) begin
               case (char_data)
                  CH_CR: col_s = C_ZERO;
                  CH_LF: begin
                     col_s      = C_ZERO;
                     row_s      = adv_row_s;
                     row_base_s = adv_base_s;
                     k_s        = A_ZERO;
                  end
                  CH_BS: begin
                     if (col_r != C_ZERO) begin
                        col_s     = col_dec_s;
                        wr_en_s   = 1'b1;
                        wr_addr_s = row_base_r + ADDR_W'(col_dec_s);
                        wr_data_s = BLANK;
                     end else begin
                        col_s = col_r;
                     end
                  end
                  CH_FF:   k_s = A_ZERO;
                  default: col_s = col_r;
               endcase
            end else begin
               k_s = k_r;
            end
         end
         default: k_s = A_ZERO;
      endcase
      ready_s = (state_r == IDLE) && (next_state_s == IDLE);
      busy_s  = !ready_s;
   end

   // Registered datapath and outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         k_r        <= A_ZERO;
         col_r      <= C_ZERO;
         row_r      <= R_ZERO;
         row_base_r <= A_ZERO;
         ready_r    <= 1'b0;
         busy_r     <= 1'b1;
         wr_en_r    <= 1'b0;
         wr_addr_r  <= A_ZERO;
         wr_data_r  <= BLANK;
      end else begin
         k_r        <= k_s;
         col_r      <= col_s;
         row_r      <= row_s;
         row_base_r <= row_base_s;
         ready_r    <= ready_s;
         busy_r     <= busy_s;
         wr_en_r    <= wr_en_s;
         wr_addr_r  <= wr_addr_s;
         wr_data_r  <= wr_data_s;
      end
   end

   assign char_ready = ready_r;
   assign busy       = busy_r;
   assign wr_en      = wr_en_r;
   assign wr_addr    = wr_addr_r;
   assign wr_data    = wr_data_r;
   assign cur_col    = col_r;
   assign cur_row    = row_r;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Self-checking bench for text_buffer_writer: directed steps plus random bytes
// checked against a screen/cursor model and a shadow copy of the character RAM.
module tb_text_buffer_writer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        char_valid = 1'b0;
   logic [7:0]  char_data = 8'h00;
   logic        char_ready, wr_en, busy;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic [6:0]  cur_col;
   logic [4:0]  cur_row;

   int vectors = 0;
   int miscompares = 0;
   int last_wait = 0;
   int oob = 0;
   int mcol = 0, mrow = 0;
   logic [7:0] scr [3000];
   logic [7:0] ram [3000];

   text_buffer_writer dut (
      .CLK(CLK), .RST(RST), .char_valid(char_valid), .char_data(char_data),
      .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Shadow of the character RAM built from the observed write strobe.
   always @(negedge CLK) begin
      if (wr_en === 1'b1) begin
         if (wr_addr < 12'd3000) ram[wr_addr] <= wr_data;
         else                    oob <= oob + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void blank_row(input int r);
      for (int c = 0; c < 100; c++) scr[r*100 + c] = 8'h20;
   endfunction

   function automatic void adv_row();
      mrow = (mrow == 29) ? 0 : mrow + 1;
      blank_row(mrow);
   endfunction

   function automatic void blank_all();
      for (int i = 0; i < 3000; i++) scr[i] = 8'h20;
      mcol = 0;
      mrow = 0;
   endfunction

   task automatic send(input logic [7:0] b);
      logic       exp_we = 1'b0;
      logic [11:0] exp_addr = 12'd0;
      logic [7:0] exp_data = 8'h00;
      logic       is_ff = 1'b0;
      int w = 0;
      char_valid = 1'b1;
      char_data  = b;
      while (char_ready !== 1'b1 && w < 5000) begin
         @(negedge CLK);
         w++;
      end
      last_wait = w;
      if (char_ready !== 1'b1) begin
         chk("accept_timeout", {63'd0, char_ready}, 64'd1);
         char_valid = 1'b0;
         return;
      end
      if (b >= 8'h20 && b <= 8'h7E) begin
         exp_we = 1'b1; exp_addr = 12'(mrow*100 + mcol); exp_data = b;
         scr[mrow*100 + mcol] = b;
         if (mcol < 99) mcol++;
         else begin mcol = 0; adv_row(); end
      end else if (b == 8'h0D) begin
         mcol = 0;
      end else if (b == 8'h0A) begin
         mcol = 0; adv_row();
      end else if (b == 8'h08) begin
         if (mcol > 0) begin
            mcol--;
            exp_we = 1'b1; exp_addr = 12'(mrow*100 + mcol); exp_data = 8'h20;
            scr[mrow*100 + mcol] = 8'h20;
         end
      end else if (b == 8'h0C) begin
         blank_all(); is_ff = 1'b1;
      end
      @(negedge CLK);
      char_valid = 1'b0;
      chk("wr_en_after_accept", {63'd0, wr_en}, {63'd0, exp_we});
      if (exp_we) chk("write_addr_data", {44'd0, wr_addr, wr_data}, {44'd0, exp_addr, exp_data});
      if (!is_ff) chk("cursor_after_accept", {52'd0, cur_col, cur_row}, {52'd0, 7'(mcol), 5'(mrow)});
   endtask

   task automatic wait_idle();
      int w = 0;
      while (char_ready !== 1'b1 && w < 5000) begin
         @(negedge CLK);
         w++;
      end
      chk("idle_reached", {63'd0, char_ready}, 64'd1);
   endtask

   task automatic ram_check(input string tag);
      int bad = 0;
      @(negedge CLK);
      for (int i = 0; i < 3000; i++) if (ram[i] !== scr[i]) bad++;
      chk(tag, 64'(bad), 64'd0);
      chk("cursor_model", {52'd0, cur_col, cur_row}, {52'd0, 7'(mcol), 5'(mrow)});
   endtask

   task automatic full_clear_check(input string tag);
      int bad = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if ({wr_en, char_ready, busy, wr_addr, wr_data} !== {1'b1, 1'b0, 1'b1, 12'(i), 8'h20}) bad++;
      end
      chk(tag, 64'(bad), 64'd0);
      @(negedge CLK);
      chk("ready_after_clear", {50'd0, wr_en, char_ready, busy, cur_col, cur_row},
          {50'd0, 1'b0, 1'b1, 1'b0, 7'd0, 5'd0});
      blank_all();
   endtask

   initial begin
      int r;
      logic [7:0] b;
      logic [7:0] held;
      repeat (3) @(negedge CLK);
      chk("reset_values", {34'd0, wr_en, char_ready, busy, wr_addr, wr_data, cur_col, cur_row},
          {34'd0, 1'b0, 1'b0, 1'b1, 12'd0, 8'h20, 7'd0, 5'd0});
      RST = 1'b0;
      full_clear_check("init_clear");

      send(8'h41);
      send(8'h42);
      chk("back_to_back", 64'(last_wait), 64'd0);
      chk("col_after_AB", {57'd0, cur_col}, 64'd2);

      send(8'h0D);
      for (int i = 0; i < 100; i++) send(8'($urandom_range(32, 126)));
      chk("last_write_addr", {52'd0, wr_addr}, 64'd99);
      held = 8'($urandom_range(32, 126));
      char_valid = 1'b1;
      char_data  = held;
      r = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if ({wr_en, char_ready, busy, wr_addr, wr_data} !== {1'b1, 1'b0, 1'b1, 12'(100 + i), 8'h20}) r++;
      end
      chk("line_clear_row1", 64'(r), 64'd0);
      send(held);
      chk("held_byte_first_idle", 64'(last_wait), 64'd1);
      ram_check("ram_after_wrap");

      for (int i = 0; i < 28; i++) send(8'h0A);
      for (int i = 0; i < 7; i++) send(8'($urandom_range(32, 126)));
      chk("cursor_7_29", {52'd0, cur_col, cur_row}, {52'd0, 7'd7, 5'd29});
      send(8'h0A);
      wait_idle();
      ram_check("ram_after_lf_wrap");
      for (int i = 0; i < 3; i++) send(8'h0A);
      for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)));
      send(8'h0D);

      send(8'h0C);
      wait_idle();
      ram_check("ram_after_ff");
      send(8'h0A);
      send(8'h0A);
      for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)));
      send(8'h08);
      send(8'h0D);
      send(8'h08);
      send(8'h07);
      ram_check("ram_after_bs");

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 19);
         if (r == 14)      b = 8'h0D;
         else if (r == 15) b = 8'h0A;
         else if (r == 16) b = 8'h08;
         else if (r == 17) b = 8'h80 + 8'($urandom_range(0, 127));
         else              b = 8'($urandom_range(32, 126));
         send(b);
      end
      wait_idle();
      ram_check("ram_after_random");

      send(8'h0C);
      r = 0;
      while (!(wr_en === 1'b1 && wr_addr == 12'd1500) && r < 4000) begin
         @(negedge CLK);
         r++;
      end
      chk("ff_reached_1500", {52'd0, wr_addr}, 64'd1500);
      #2 RST = 1'b1;
      #1;
      chk("async_reset_values", {34'd0, wr_en, char_ready, busy, wr_addr, wr_data, cur_col, cur_row},
          {34'd0, 1'b0, 1'b0, 1'b1, 12'd0, 8'h20, 7'd0, 5'd0});
      @(negedge CLK);
      RST = 1'b0;
      full_clear_check("restart_clear");
      ram_check("ram_after_restart");
      chk("addr_in_range", 64'(oob), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
